// File: rtl/coef_pkg.sv
// Shared constants and types for the biquad coefficient loader.
package coef_pkg;
  localparam int NCOEF = 5;
  localparam int CW    = 16;
  localparam int AW    = 3;

  localparam logic [AW-1:0] ADR_A11 = 3'd0;
  localparam logic [AW-1:0] ADR_A12 = 3'd1;
  localparam logic [AW-1:0] ADR_B10 = 3'd2;
  localparam logic [AW-1:0] ADR_B11 = 3'd3;
  localparam logic [AW-1:0] ADR_B12 = 3'd4;

  localparam int ERR_TMO = 0;
  localparam int ERR_MIS = 1;

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} ld_state_e;
endpackage

// File: rtl/wb_ack_timer.sv
// Saturating count of consecutive unacknowledged strobe cycles.
// timeout_o flags the cycle that is the ACK_TIMEOUT-th wait, so the owner
// can abort on the edge that closes it.
module wb_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic cnt_i,
  output logic timeout_o
);
  localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = 8'd0;
    else if (cnt_i && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
  end

  // wait counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = cnt_i && !clr_i && (cnt_q >= LAST);
endmodule

// File: rtl/coef_loader.sv
// Wishbone master that writes a biquad coefficient set (a11,a12,b10,b11,b12)
// to addresses 0..4, optionally reading it back for comparison.
// Build option: define COEF_LOADER_VERIFY_EN to include the readback pass.
module coef_loader
  import coef_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] a11_i,
  input  logic [CW-1:0] a12_i,
  input  logic [CW-1:0] b10_i,
  input  logic [CW-1:0] b11_i,
  input  logic [CW-1:0] b12_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    err_o,
  output logic [AW-1:0] err_adr_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [CW-1:0] dat_o,
  input  logic [CW-1:0] dat_i,
  input  logic          ack_i
);
  ld_state_e                   state_q, state_d;
  logic [AW-1:0]               adr_q, adr_d;
  logic [NCOEF-1:0][CW-1:0]    shadow_q, shadow_d;
  logic [1:0]                  err_q, err_d;
  logic [AW-1:0]               err_adr_q, err_adr_d;
  logic                        timeout;

  // The counter is idle whenever no beat is outstanding; every ack restarts
  // it, which also covers entry into a new state since transitions ride acks.
  wb_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_tmr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (ack_i || !stb_o),
    .cnt_i     (stb_o && !ack_i),
    .timeout_o (timeout)
  );

`ifndef COEF_LOADER_VERIFY_EN
  logic dat_unused;
  assign dat_unused = ^dat_i;
`endif

  // sequencer: next state, address, shadow capture and error capture
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shadow_d  = {b12_i, b11_i, b10_i, a12_i, a11_i};
          err_d     = 2'b00;
          err_adr_d = '0;
          adr_d     = ADR_A11;
          state_d   = WR;
        end
      end
      WR: begin
        if (ack_i) begin
          if (adr_q == ADR_B12) begin
            adr_d = ADR_A11;
`ifdef COEF_LOADER_VERIFY_EN
            state_d = RD;
`else
            state_d = FIN;
`endif
          end else begin
            adr_d = adr_q + 3'd1;
          end
        end else if (timeout) begin
          err_d[ERR_TMO] = 1'b1;
          err_adr_d      = adr_q;
          state_d        = FIN;
        end
      end
      RD: begin
`ifdef COEF_LOADER_VERIFY_EN
        if (ack_i) begin
          if (dat_i != shadow_q[adr_q]) begin
            err_d[ERR_MIS] = 1'b1;
            err_adr_d      = adr_q;
            state_d        = FIN;
          end else if (adr_q == ADR_B12) begin
            state_d = FIN;
          end else begin
            adr_d = adr_q + 3'd1;
          end
        end else if (timeout) begin
          err_d[ERR_TMO] = 1'b1;
          err_adr_d      = adr_q;
          state_d        = FIN;
        end
`else
        state_d = FIN;
`endif
      end
      FIN: begin
        adr_d   = ADR_A11;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      shadow_q  <= '0;
      err_q     <= 2'b00;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      shadow_q  <= shadow_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  // bus outputs decode straight from registered state, so cyc/stb stay
  // asserted across all beats of one sequence and drop together in FIN
  always_comb begin
    busy_o    = (state_q == WR) || (state_q == RD);
    stb_o     = busy_o;
    cyc_o     = busy_o;
    we_o      = (state_q == WR);
    adr_o     = busy_o ? adr_q : '0;
    dat_o     = we_o ? shadow_q[adr_q] : '0;
    done_o    = (state_q == FIN);
    err_adr_o = err_adr_q;
`ifdef COEF_LOADER_VERIFY_EN
    err_o     = err_q;
`else
    err_o     = {1'b0, err_q[ERR_TMO]};
`endif
  end
endmodule
